// File: rtl/ahb_sram_sink_if.sv
// ahb_sram_sink_if: AHB-lite write-side signals between the bus master and the SRAM sink.
//   HWRITE  1    write transfer flag
//   HBURST  3    burst type (carried, not decoded by the sink)
//   HTRANS  2    0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   HADDR   32   address-phase byte address
//   HWDATA  128  data-phase write data
// Modports: master drives everything, slave samples everything.
interface ahb_sram_sink_if;
    logic         HWRITE;
    logic [2:0]   HBURST;
    logic [1:0]   HTRANS;
    logic [31:0]  HADDR;
    logic [127:0] HWDATA;

    modport master (output HWRITE, HBURST, HTRANS, HADDR, HWDATA);
    modport slave  (input  HWRITE, HBURST, HTRANS, HADDR, HWDATA);
endinterface

// File: rtl/ahb_sram_sink.sv
// ahb_sram_sink: zero-wait-state AHB-lite write-only slave storing 128-bit beats into a
// DEPTH-entry buffer, with a 1-cycle host read port and per-burst status.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ahb (slave)        HWRITE/HBURST/HTRANS/HADDR/HWDATA
//   rd_en, rd_idx      host read request and entry index
//   rd_data, rd_valid  read data and its 1-cycle qualifier
//   burst_done         1-cycle pulse when a write burst ends
//   burst_len          accepted beats of the last ended burst (held)
//   wr_count           accepted beats since reset/clear, saturating
//   addr_err           sticky flag: a misaligned/out-of-range beat was dropped
//   clr                clears wr_count, addr_err, burst_len
//   rd_perr            (SRAM_PARITY_EN only) stored-parity mismatch on the read entry
// Optional feature: define SRAM_PARITY_EN to store an even-parity bit per entry.
module ahb_sram_sink #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned LW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb_sram_sink_if.slave       ahb,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_idx,
    output logic [127:0]         rd_data,
    output logic                 rd_valid,
    output logic                 burst_done,
    output logic [LW-1:0]        burst_len,
    output logic [15:0]          wr_count,
    output logic                 addr_err,
    input  logic                 clr
`ifdef SRAM_PARITY_EN
    ,
    output logic                 rd_perr
`endif
);

    typedef enum logic {S_IDLE, S_DATA} state_e;

    state_e          state_q;
    logic [AW-1:0]   idx_q;      // entry index of the pending data phase
    logic            drop_q;     // pending data phase targets an illegal address
    logic [LW-1:0]   beats_q;    // accepted beats so far in the current burst
    logic [127:0]    mem_q [DEPTH];
`ifdef SRAM_PARITY_EN
    logic            par_q [DEPTH];
`endif

    logic            addr_vld_c;
    logic            nonseq_c;
    logic [31:0]     off_c;
    logic [AW-1:0]   idx_c;
    logic            drop_c;
    logic            accept_c;
    logic            burst_end_c;
    logic [LW-1:0]   beats_fin_c;
    logic            unused_bits;

    // Address-phase decode: NONSEQ/SEQ writes only; SEQ from IDLE starts a burst like NONSEQ.
    assign addr_vld_c  = ahb.HWRITE && ahb.HTRANS[1];
    assign nonseq_c    = (ahb.HTRANS == 2'b10);
    assign off_c       = ahb.HADDR - BASE_ADDR;
    assign idx_c       = off_c[AW+3:4];
    assign drop_c      = (ahb.HADDR[3:0] != 4'd0) || (ahb.HADDR < BASE_ADDR)
                      || (off_c[31:4] >= 28'(DEPTH));
    assign unused_bits = ^{ahb.HBURST, off_c[3:0]};

    // Data phase completes this cycle; a burst ends on any non-write or on a fresh NONSEQ.
    assign accept_c    = (state_q == S_DATA) && !drop_q;
    assign burst_end_c = (state_q == S_DATA) && (!addr_vld_c || nonseq_c);
    assign beats_fin_c = (accept_c && (beats_q != '1)) ? beats_q + LW'(1) : beats_q;

    // Burst FSM, status counters and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            drop_q     <= 1'b0;
            beats_q    <= '0;
            burst_done <= 1'b0;
            burst_len  <= '0;
            wr_count   <= '0;
            addr_err   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
`ifdef SRAM_PARITY_EN
            rd_perr    <= 1'b0;
`endif
        end else begin
            burst_done <= 1'b0;
            rd_valid   <= rd_en;
            if (rd_en) begin
                rd_data <= mem_q[rd_idx];
`ifdef SRAM_PARITY_EN
                rd_perr <= (^mem_q[rd_idx]) ^ par_q[rd_idx];
`endif
            end

            state_q <= addr_vld_c ? S_DATA : S_IDLE;
            if (addr_vld_c) begin
                idx_q  <= idx_c;
                drop_q <= drop_c;
            end

            if (burst_end_c) begin
                burst_done <= 1'b1;
                burst_len  <= beats_fin_c;
            end
            beats_q <= (burst_end_c || (state_q == S_IDLE)) ? '0 : beats_fin_c;

            if ((state_q == S_DATA) && drop_q) begin
                addr_err <= 1'b1;
            end
            if (accept_c && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end

            // Clear wins over same-cycle updates.
            if (clr) begin
                wr_count  <= '0;
                addr_err  <= 1'b0;
                burst_len <= '0;
            end
        end
    end

    // Storage is not reset; a data phase coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            mem_q[idx_q] <= ahb.HWDATA;
`ifdef SRAM_PARITY_EN
            par_q[idx_q] <= ^ahb.HWDATA;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_sram_sink.sv
// tb_ahb_sram_sink: randomized + directed stimulus for ahb_sram_sink, checked by a reference
// model (array memory, counters) feeding scoreboard queues drained by a negedge monitor.
// Build with SRAM_PARITY_EN defined to also exercise rd_perr.
module tb_ahb_sram_sink;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] B     = 32'h0000_1000;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, rd_en, clr;
    logic [AW-1:0]  rd_idx;
    logic [127:0]   rd_data;
    logic           rd_valid, burst_done, addr_err;
    logic [LW-1:0]  burst_len;
    logic [15:0]    wr_count;
`ifdef SRAM_PARITY_EN
    logic           rd_perr;
`endif

    ahb_sram_sink_if bus();

    ahb_sram_sink #(.DEPTH(DEPTH), .BASE_ADDR(B)) dut (
        .clk(clk), .rst(rst), .ahb(bus),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .burst_done(burst_done), .burst_len(burst_len), .wr_count(wr_count),
        .addr_err(addr_err), .clr(clr)
`ifdef SRAM_PARITY_EN
        , .rd_perr(rd_perr)
`endif
    );

    typedef struct { int cyc; bit known; logic [127:0] data; bit perr; } rd_exp_t;
    typedef struct { int cyc; int len; } bu_exp_t;

    rd_exp_t rdq[$];
    bu_exp_t bq[$];

    // Reference model state
    logic [127:0] ref_mem [DEPTH];
    bit           ref_wr  [DEPTH];
    bit           ref_flip[DEPTH];
    int           cyc = 0;
    bit           p_vld = 0;
    logic [31:0]  p_addr = '0;
    int           beats = 0;
    bit           in_burst = 0;
    int           exp_wrc = 0;
    bit           exp_err = 0;
    int           exp_len = 0;
    bit           rd_zero = 1;
    int           bd_cnt = 0, bd_seen = 0, bd_idx = 0;
    bit           sim_done = 0;
    int           n_cmp = 0, n_fail = 0;

    function automatic bit legal(input logic [31:0] a);
        if ((a % 32'd16) != 0) return 1'b0;
        if (a < B) return 1'b0;
        return ((a - B) / 32'd16) < DEPTH;
    endfunction

    // Model: applies the bus/host rules at each rising edge from the values driven in that cycle.
    always @(posedge clk) begin
        rd_exp_t e;
        bu_exp_t be;
        bit      new_vld, ended;
        int      k;
        cyc++;
        if (bd_cnt != bd_seen) begin
            bd_seen = bd_cnt;
            ref_flip[bd_idx] = 1'b1;
            ref_mem[bd_idx][0] = ~ref_mem[bd_idx][0];
        end
        if (rst) begin
            p_vld = 0; in_burst = 0; beats = 0;
            exp_wrc = 0; exp_err = 0; exp_len = 0; rd_zero = 1;
        end else begin
            if (rd_en) begin
                k = int'(rd_idx);
                e.cyc = cyc; e.known = ref_wr[k]; e.data = ref_mem[k];
                e.perr = ref_wr[k] && ref_flip[k];
                rdq.push_back(e);
                rd_zero = 0;
            end
            new_vld = bus.HWRITE && (bus.HTRANS == 2'd2 || bus.HTRANS == 2'd3);
            ended   = in_burst && (!new_vld || bus.HTRANS == 2'd2);
            if (p_vld) begin
                if (legal(p_addr)) begin
                    k = int'((p_addr - B) / 32'd16);
                    ref_mem[k] = bus.HWDATA; ref_wr[k] = 1; ref_flip[k] = 0;
                    if (beats < (1 << LW) - 1) beats++;
                    if (exp_wrc < 65535) exp_wrc++;
                end else begin
                    exp_err = 1;
                end
            end
            if (ended) begin
                be.cyc = cyc; be.len = clr ? 0 : beats;
                bq.push_back(be);
                exp_len = beats;
            end
            if (ended || !in_burst) beats = 0;
            in_burst = new_vld;
            p_vld    = new_vld;
            p_addr   = bus.HADDR;
            if (clr) begin exp_wrc = 0; exp_err = 0; exp_len = 0; end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries when the DUT pulses, checks held status every cycle.
    always @(negedge clk) begin
        rd_exp_t e;
        bu_exp_t be;
        if (rd_valid) begin
            if (rdq.size() == 0) begin
                chk("rd_valid_unexpected", 128'(1), 128'(0));
            end else begin
                e = rdq.pop_front();
                chk("rd_valid_cycle", 128'(cyc), 128'(e.cyc));
                if (e.known) chk("rd_data", rd_data, e.data);
`ifdef SRAM_PARITY_EN
                chk("rd_perr", 128'(rd_perr), 128'(e.perr));
`endif
            end
        end else if (rdq.size() != 0 && rdq[0].cyc <= cyc) begin
            e = rdq.pop_front();
            chk("rd_valid_missing", 128'(0), 128'(1));
        end
        if (burst_done) begin
            if (bq.size() == 0) begin
                chk("burst_done_unexpected", 128'(1), 128'(0));
            end else begin
                be = bq.pop_front();
                chk("burst_done_cycle", 128'(cyc), 128'(be.cyc));
                chk("burst_len_at_done", 128'(burst_len), 128'(be.len));
            end
        end else if (bq.size() != 0 && bq[0].cyc <= cyc) begin
            be = bq.pop_front();
            chk("burst_done_missing", 128'(0), 128'(1));
        end
        chk("wr_count", 128'(wr_count), 128'(exp_wrc));
        chk("addr_err", 128'(addr_err), 128'(exp_err));
        chk("burst_len_held", 128'(burst_len), 128'(exp_len));
        if (rd_zero) begin
            chk("rd_data_reset", rd_data, 128'(0));
`ifdef SRAM_PARITY_EN
            chk("rd_perr_reset", 128'(rd_perr), 128'(0));
`endif
        end
        if (sim_done) begin
            chk("rdq_drained", 128'(rdq.size()), 128'(0));
            chk("bq_drained", 128'(bq.size()), 128'(0));
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic re, input logic [AW-1:0] ri, input logic c, input logic r);
        bus.HTRANS = tr;  bus.HWRITE = wr; bus.HADDR = a;
        bus.HBURST = 3'($urandom);
        bus.HWDATA = {$urandom, $urandom, $urandom, $urandom};
        rd_en = re; rd_idx = ri; clr = c; rst = r;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input int i);
        drive(2'd0, 1'b0, 32'd0, 1'b1, AW'(i), 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_addr();
        int m;
        m = $urandom_range(0, 9);
        case (m)
            0: return B + 32'(16 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 15));
            1: return B + 32'(16 * (DEPTH + $urandom_range(0, 3)));
            2: return B - 32'(16 * $urandom_range(1, 4));
            default: return B + 32'(16 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        int          len, gap;
        logic [1:0]  tr;
        logic        wr;
        drive(2'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1);
        drive(2'd0, 1'b0, 32'd0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        // Three-beat burst to entries 0..2, then idle.
        drive(2'd2, 1'b1, B,      1'b0, '0, 1'b0, 1'b0);
        drive(2'd3, 1'b1, B + 16, 1'b0, '0, 1'b0, 1'b0);
        drive(2'd3, 1'b1, B + 32, 1'b0, '0, 1'b0, 1'b0);
        idle(); idle();
        rd(0); rd(1); rd(2);
        // Read entry 1 in the same cycle it is rewritten, then read it again.
        drive(2'd2, 1'b1, B + 16, 1'b0, '0, 1'b0, 1'b0);
        rd(1); rd(1); idle();
        // Dropped beats: past the end, unaligned, below base; then clear.
        drive(2'd2, 1'b1, B + 16 * DEPTH, 1'b0, '0, 1'b0, 1'b0);
        drive(2'd2, 1'b1, B + 4,          1'b0, '0, 1'b0, 1'b0);
        drive(2'd2, 1'b1, B - 16,         1'b0, '0, 1'b0, 1'b0);
        idle(); idle();
        drive(2'd0, 1'b0, 32'd0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        // Two-beat burst followed immediately by a one-beat burst.
        drive(2'd2, 1'b1, B + 48, 1'b0, '0, 1'b0, 1'b0);
        drive(2'd3, 1'b1, B + 64, 1'b0, '0, 1'b0, 1'b0);
        drive(2'd2, 1'b1, B + 80, 1'b0, '0, 1'b0, 1'b0);
        idle(); idle();
        // Reset during the second data phase of a three-beat burst.
        drive(2'd2, 1'b1, B + 112, 1'b0, '0, 1'b0, 1'b0);
        idle();
        drive(2'd2, 1'b1, B + 96,  1'b0, '0, 1'b0, 1'b0);
        drive(2'd3, 1'b1, B + 112, 1'b0, '0, 1'b0, 1'b0);
        drive(2'd3, 1'b1, B + 128, 1'b0, '0, 1'b0, 1'b1);
        idle(); idle();
        rd(6); rd(7); rd(8); rd(3); rd(4); rd(5);
`ifdef SRAM_PARITY_EN
        // Parity: store 1 in entry 9, corrupt bit 0 behind the bus, read back.
        drive(2'd2, 1'b1, B + 144, 1'b0, '0, 1'b0, 1'b0);
        bus.HTRANS = 2'd0; bus.HWRITE = 1'b0; bus.HWDATA = 128'h1;
        @(posedge clk); #1;
        idle();
        dut.mem_q[9][0] = ~dut.mem_q[9][0];
        bd_idx = 9; bd_cnt = bd_cnt + 1;
        idle();
        rd(9); rd(12); idle();
`endif
        // Randomized bursts with reads, clears, gaps, BUSY and occasional reset.
        for (int b = 0; b < 70; b++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                if (j == 0) tr = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd2;
                else        tr = ($urandom_range(0, 11) == 0) ? 2'd1 : 2'd3;
                wr = ($urandom_range(0, 15) != 0);
                drive(tr, wr, pick_addr(), 1'($urandom_range(0, 2) == 0),
                      AW'($urandom_range(0, DEPTH - 1)), 1'b0,
                      1'($urandom_range(0, 99) == 0));
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive(2'd0, 1'b0, 32'd0, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH - 1)),
                      1'($urandom_range(0, 9) == 0), 1'b0);
            end
        end
        idle(); idle();
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(); idle(); idle();
        sim_done = 1;
    end

endmodule
